axi_master: RTL and testbench

- Initiator-side AXI4-Lite bridge that turns a simple single-outstanding request/ready port (core load/store unit, boot loader, DMA) into AXI4-Lite read and write transactions.
- Sits between a requester and the interconnect, upstream of the memory-side AXI slave wrappers.
- Exactly one transaction in flight at a time; no bursts, no IDs.

---
 rtl/axi_master.sv | 155 +++++++++++++++
 tb/tb_axi_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master.sv
// Single-outstanding request port to AXI4-Lite initiator; all outputs registered, zero-wait completion 3 edges after request.
// Valids hold until their handshake; requester is stalled (no hs_ready_o) while the slave withholds ready/valid.
`timescale 1ns/1ps
module axi_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ALIGN_ADDR = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    hs_read_i,
  input  logic                    hs_write_i,
  input  logic [ADDR_WIDTH-1:0]   hs_addr_i,
  input  logic [DATA_WIDTH-1:0]   hs_data_i,
  input  logic [DATA_WIDTH/8-1:0] hs_byte_select_i,
  output logic                    hs_ready_o,
  output logic [DATA_WIDTH-1:0]   hs_data_o,
  output logic                    hs_error_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    (ALIGN_ADDR != 0) ? {{(ADDR_WIDTH-2){1'b1}}, 2'b00} : {ADDR_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic                    arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic                    hs_ready_d, hs_error_d;
  logic [DATA_WIDTH-1:0]   hs_data_d, wdata_d;
  logic [ADDR_WIDTH-1:0]   araddr_d, awaddr_d, req_addr;
  logic [DATA_WIDTH/8-1:0] wstrb_d;
  logic                    aw_done, w_done;

  assign req_addr = hs_addr_i & ALIGN_MASK;
  // A channel counts as done if its valid already dropped or it handshakes on this edge.
  assign aw_done  = !awvalid_o || awready_i;
  assign w_done   = !wvalid_o || wready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      arvalid_o  <= 1'b0;
      rready_o   <= 1'b0;
      awvalid_o  <= 1'b0;
      wvalid_o   <= 1'b0;
      bready_o   <= 1'b0;
      hs_ready_o <= 1'b0;
      hs_error_o <= 1'b0;
      hs_data_o  <= '0;
      araddr_o   <= '0;
      awaddr_o   <= '0;
      wdata_o    <= '0;
      wstrb_o    <= '0;
    end else begin
      state_q    <= state_d;
      arvalid_o  <= arvalid_d;
      rready_o   <= rready_d;
      awvalid_o  <= awvalid_d;
      wvalid_o   <= wvalid_d;
      bready_o   <= bready_d;
      hs_ready_o <= hs_ready_d;
      hs_error_o <= hs_error_d;
      hs_data_o  <= hs_data_d;
      araddr_o   <= araddr_d;
      awaddr_o   <= awaddr_d;
      wdata_o    <= wdata_d;
      wstrb_o    <= wstrb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arvalid_d  = arvalid_o;
    rready_d   = rready_o;
    awvalid_d  = awvalid_o;
    wvalid_d   = wvalid_o;
    bready_d   = bready_o;
    hs_ready_d = 1'b0;
    hs_error_d = 1'b0;
    hs_data_d  = hs_data_o;
    araddr_d   = araddr_o;
    awaddr_d   = awaddr_o;
    wdata_d    = wdata_o;
    wstrb_d    = wstrb_o;
    unique case (state_q)
      IDLE: begin
        if (hs_write_i) begin
          awaddr_d  = req_addr;
          wdata_d   = hs_data_i;
          wstrb_d   = hs_byte_select_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (hs_read_i) begin
          araddr_d  = req_addr;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        // Read data is loaded even on an error response.
        if (rvalid_i) begin
          hs_data_d  = rdata_i;
          hs_error_d = (rresp_i != 2'b00);
          hs_ready_d = 1'b1;
          rready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      WR_REQ: begin
        if (awvalid_o && awready_i) awvalid_d = 1'b0;
        if (wvalid_o && wready_i)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_i) begin
          hs_error_d = (bresp_i != 2'b00);
          hs_ready_d = 1'b1;
          bready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: a configurable-wait AXI-Lite slave plus a transaction-level
// scoreboard checked every cycle, and literal expectations per scenario.
`timescale 1ns/1ps
module tb_axi_master;

  logic        clk_i, rst_i;
  logic        hs_read_i, hs_write_i;
  logic [31:0] hs_addr_i, hs_data_i;
  logic [3:0]  hs_byte_select_i;
  logic        hs_ready_o, hs_error_o;
  logic [31:0] hs_data_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o;
  logic [31:0] araddr_o, rdata_i;
  logic [1:0]  rresp_i, bresp_i;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [31:0] awaddr_o, wdata_o;
  logic [3:0]  wstrb_o;

  axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALIGN_ADDR(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .hs_read_i(hs_read_i), .hs_write_i(hs_write_i), .hs_addr_i(hs_addr_i),
    .hs_data_i(hs_data_i), .hs_byte_select_i(hs_byte_select_i),
    .hs_ready_o(hs_ready_o), .hs_data_o(hs_data_o), .hs_error_o(hs_error_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave configuration and requester intent, written by the stimulus process.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] rd_val = 32'h0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_addr = 32'h0, cur_data = 32'h0;
  logic [3:0]  cur_strb = 4'h0;

  // Scoreboard state.
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          cyc = 0, n_ar = 0, n_aw = 0, ar_rise_cyc = 0, done_cyc = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, ar_hi = 0;
  logic [31:0] last_araddr = 32'h0, exp_data = 32'h0;
  logic        exp_ready, exp_err, r_expect = 1'b0, b_expect = 1'b0;
  logic        aw_seen = 1'b0, w_seen = 1'b0;
  logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
  logic        p_arvalid = 1'b0, p_rready = 1'b0, p_awvalid = 1'b0, p_wvalid = 1'b0, p_bready = 1'b0;
  logic [31:0] p_araddr = 32'h0, p_awaddr = 32'h0, p_wdata = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      // Handshakes that happened on the edge just before this sample point.
      hs_ar = p_arvalid && arready_i;
      hs_r  = p_rready  && rvalid_i;
      hs_aw = p_awvalid && awready_i;
      hs_w  = p_wvalid  && wready_i;
      hs_b  = p_bready  && bvalid_i;
      if (!rst_i) begin
        exp_data = 32'h0; aw_seen = 1'b0; w_seen = 1'b0;
        r_expect = 1'b0; b_expect = 1'b0;
      end else begin
        exp_ready = hs_r || hs_b;
        if (hs_r) exp_data = rd_val;
        exp_err = hs_r ? (r_resp != 2'b00) : (hs_b ? (b_resp != 2'b00) : 1'b0);
        chk("hs_ready", 64'(hs_ready_o), 64'(exp_ready));
        chk("hs_error", 64'(hs_error_o), 64'(exp_err));
        chk("hs_data", 64'(hs_data_o), 64'(exp_data));
        if (hs_ready_o) done_cyc = cyc;

        if (p_arvalid) begin
          if (hs_ar) chk("ar_drop", 64'(arvalid_o), 64'd0);
          else begin
            chk("ar_hold", 64'(arvalid_o), 64'd1);
            chk("araddr_hold", 64'(araddr_o), 64'(p_araddr));
          end
        end else if (arvalid_o) begin
          n_ar++; ar_rise_cyc = cyc; last_araddr = araddr_o; ar_hi = 0;
          chk("ar_kind", 64'(cur_wr), 64'd0);
          chk("araddr", 64'(araddr_o), 64'(cur_addr & ~32'h3));
        end
        if (arvalid_o) ar_hi++;
        if (hs_ar) r_expect = 1'b1;
        if (hs_r)  r_expect = 1'b0;
        chk("rready", 64'(rready_o), 64'(r_expect));

        if (p_awvalid) begin
          if (hs_aw) begin
            chk("aw_drop", 64'(awvalid_o), 64'd0);
            aw_seen = 1'b1; aw_hs_cyc = cyc;
          end else begin
            chk("aw_hold", 64'(awvalid_o), 64'd1);
            chk("awaddr_hold", 64'(awaddr_o), 64'(p_awaddr));
          end
        end else if (awvalid_o) begin
          n_aw++;
          chk("aw_kind", 64'(cur_wr), 64'd1);
          chk("awaddr", 64'(awaddr_o), 64'(cur_addr & ~32'h3));
          chk("w_with_aw", 64'(wvalid_o), 64'd1);
          chk("wdata", 64'(wdata_o), 64'(cur_data));
          chk("wstrb", 64'(wstrb_o), 64'(cur_strb));
        end
        if (p_wvalid) begin
          if (hs_w) begin
            chk("w_drop", 64'(wvalid_o), 64'd0);
            w_seen = 1'b1; w_hs_cyc = cyc;
          end else begin
            chk("w_hold", 64'(wvalid_o), 64'd1);
            chk("wdata_hold", 64'(wdata_o), 64'(p_wdata));
            chk("wstrb_hold", 64'(wstrb_o), 64'(p_wstrb));
          end
        end
        if (hs_b) b_expect = 1'b0;
        if (aw_seen && w_seen) begin
          b_expect = 1'b1; aw_seen = 1'b0; w_seen = 1'b0;
        end
        chk("bready", 64'(bready_o), 64'(b_expect));
      end

      // Slave: each ready/valid rises after the configured number of waiting cycles.
      if (arvalid_o) begin arready_i = (ar_cnt == ar_wait); ar_cnt++; end
      else begin arready_i = 1'b0; ar_cnt = 0; end
      if (rready_o) begin
        rvalid_i = (r_cnt == r_wait); r_cnt++;
        rdata_i  = rvalid_i ? rd_val : 32'h0BAD_F00D;
        rresp_i  = rvalid_i ? r_resp : 2'b11;
      end else begin
        rvalid_i = 1'b0; r_cnt = 0; rdata_i = 32'h0BAD_F00D; rresp_i = 2'b11;
      end
      if (awvalid_o) begin awready_i = (aw_cnt == aw_wait); aw_cnt++; end
      else begin awready_i = 1'b0; aw_cnt = 0; end
      if (wvalid_o) begin wready_i = (w_cnt == w_wait); w_cnt++; end
      else begin wready_i = 1'b0; w_cnt = 0; end
      if (bready_o) begin
        bvalid_i = (b_cnt == b_wait); b_cnt++;
        bresp_i  = bvalid_i ? b_resp : 2'b11;
      end else begin
        bvalid_i = 1'b0; b_cnt = 0; bresp_i = 2'b11;
      end

      p_arvalid = arvalid_o; p_rready = rready_o; p_awvalid = awvalid_o;
      p_wvalid = wvalid_o; p_bready = bready_o;
      p_araddr = araddr_o; p_awaddr = awaddr_o; p_wdata = wdata_o; p_wstrb = wstrb_o;
    end
  end

  task automatic start_req(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk_i); #1;
    cur_wr = wr; cur_addr = addr; cur_data = data; cur_strb = strb;
    hs_write_i = wr; hs_read_i = rd; hs_addr_i = addr;
    hs_data_i = data; hs_byte_select_i = strb;
  endtask

  // Latency is counted in edges from the edge the request went up to the edge raising hs_ready_o.
  task automatic wait_done(output int lat);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk_i);
      n++;
      if (hs_ready_o) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    lat = n - 1;
  endtask

  task automatic drop_req(input logic keep_rd);
    @(posedge clk_i); #1;
    hs_write_i = 1'b0;
    hs_read_i  = keep_rd;
    if (keep_rd) cur_wr = 1'b0;
  endtask

  task automatic set_waits(input int a, input int r, input int aw, input int w, input int b);
    ar_wait = a; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
  endtask

  initial begin
    int lat, n_ar0, n_aw0, d;
    logic seen;
    rst_i = 1'b0;
    hs_read_i = 1'b0; hs_write_i = 1'b0; hs_addr_i = 32'h0; hs_data_i = 32'h0;
    hs_byte_select_i = 4'h0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0; rresp_i = 2'b00;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    #2;
    chk("reset_ctrl", 64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o,
                           hs_ready_o, hs_error_o, wstrb_o}), 64'd0);
    chk("reset_rd", 64'({hs_data_o, araddr_o}), 64'd0);
    chk("reset_wr", 64'({awaddr_o, wdata_o}), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Zero-wait read, OKAY.
    set_waits(0, 0, 0, 0, 0); rd_val = 32'hDEAD_BEEF; r_resp = 2'b00;
    start_req(1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'h0);
    wait_done(lat);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_data", 64'(hs_data_o), 64'hDEAD_BEEF);
    chk("t1_error", 64'(hs_error_o), 64'd0);
    chk("t1_ar_cycles", 64'(ar_hi), 64'd1);
    chk("t1_araddr", 64'(last_araddr), 64'h104);
    drop_req(1'b0);

    // Write, awready three cycles ahead of wready.
    set_waits(0, 0, 1, 4, 0); b_resp = 2'b00;
    start_req(1'b1, 1'b0, 32'h0000_0208, 32'h1234_5678, 4'b0011);
    wait_done(lat);
    chk("t2_latency", 64'(lat), 64'd7);
    chk("t2_aw_before_w", 64'(w_hs_cyc - aw_hs_cyc), 64'd3);
    chk("t2_error", 64'(hs_error_o), 64'd0);
    chk("t2_data_kept", 64'(hs_data_o), 64'hDEAD_BEEF);
    drop_req(1'b0);

    // Write with delayed SLVERR response.
    set_waits(0, 0, 0, 0, 2); b_resp = 2'b10;
    start_req(1'b1, 1'b0, 32'h0000_020C, 32'hFFFF_0000, 4'b1100);
    wait_done(lat);
    chk("t2b_latency", 64'(lat), 64'd5);
    chk("t2b_error", 64'(hs_error_o), 64'd1);
    chk("t2b_data_kept", 64'(hs_data_o), 64'hDEAD_BEEF);
    drop_req(1'b0);

    // Stalled read with SLVERR; data still loaded.
    set_waits(4, 2, 0, 0, 0); rd_val = 32'h5555_AAAA; r_resp = 2'b10;
    start_req(1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
    wait_done(lat);
    chk("t3_latency", 64'(lat), 64'd9);
    chk("t3_error", 64'(hs_error_o), 64'd1);
    chk("t3_data", 64'(hs_data_o), 64'h5555_AAAA);
    chk("t3_ar_cycles", 64'(ar_hi), 64'd5);
    drop_req(1'b0);

    // Read and write together: write first, read re-sampled after the completion pulse.
    set_waits(0, 0, 0, 0, 0); b_resp = 2'b00; r_resp = 2'b00; rd_val = 32'h1111_2222;
    n_ar0 = n_ar; n_aw0 = n_aw;
    start_req(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF);
    wait_done(lat);
    chk("t4_write_latency", 64'(lat), 64'd3);
    chk("t4_write_issued", 64'(n_aw - n_aw0), 64'd1);
    chk("t4_no_read_yet", 64'(n_ar - n_ar0), 64'd0);
    drop_req(1'b1);
    d = done_cyc;
    wait_done(lat);
    chk("t4_read_issued", 64'(n_ar - n_ar0), 64'd1);
    chk("t4_ar_after_done", 64'(ar_rise_cyc - d), 64'd2);
    chk("t4_read_data", 64'(hs_data_o), 64'h1111_2222);
    drop_req(1'b0);

    // Asynchronous reset while both write valids are up.
    set_waits(0, 0, 20, 20, 0);
    start_req(1'b1, 1'b0, 32'h0000_0500, 32'hA5A5_5A5A, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (awvalid_o && wvalid_o) seen = 1'b1;
    end
    chk("t5_wr_pending", 64'(seen), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("t5_valids_cleared", 64'({awvalid_o, wvalid_o, arvalid_o, rready_o, bready_o}), 64'd0);
    chk("t5_regs_cleared", 64'({awaddr_o, wdata_o}), 64'd0);
    chk("t5_out_cleared", 64'({hs_ready_o, hs_error_o, wstrb_o}), 64'd0);
    hs_write_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("t5_idle_after_reset", 64'({hs_ready_o, arvalid_o, awvalid_o, wvalid_o}), 64'd0);
    end

    // Unaligned read address is word-aligned on AR.
    set_waits(0, 0, 0, 0, 0); rd_val = 32'h7777_0013; r_resp = 2'b00;
    start_req(1'b0, 1'b1, 32'h0000_0013, 32'h0, 4'h0);
    wait_done(lat);
    chk("t6_latency", 64'(lat), 64'd3);
    chk("t6_araddr_aligned", 64'(last_araddr), 64'h10);
    chk("t6_data", 64'(hs_data_o), 64'h7777_0013);
    drop_req(1'b0);
    repeat (3) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
